// File: rtl/mux_seq.sv
// -----------------------------------------------------------------------------
// mux_seq -- sequencing controller for an external 128-bit-to-byte mux
//            (mux .out = .in[8*sel +: 8]).
//
// Takes one wide word plus a start lane and a byte count over a valid/ready
// handshake and holds the word on mux_in. It then steps sel across the
// requested lanes and streams the returned byte (mux_out) out one beat at a
// time over a valid/ready byte stream.
//
// Build option:
//   MUX_SEQ_DESCEND_EN  defined   -> sel steps downward (wraps 0 -> NBYTES-1)
//                       undefined -> sel steps upward   (wraps NBYTES-1 -> 0)
//
// Ports:
//   clk         in   clock
//   nRst        in   synchronous active-low reset
//   in_data     in   word to serialize
//   in_start    in   first lane to emit
//   in_cnt      in   bytes to emit minus one
//   in_valid    in   word offered
//   in_ready    out  word accepted when in_valid & in_ready (combinational)
//   mux_in      out  held word, drives mux .in
//   sel         out  drives mux .sel
//   mux_out     in   byte returned from mux .out
//   out_data    out  emitted byte (combinational pass-through of mux_out)
//   out_valid   out  byte valid
//   out_ready   in   consumer accepts byte when out_valid & out_ready
//   frame_done  out  one-cycle pulse the cycle after the last byte handshake
//   busy        out  high while sending a frame
// -----------------------------------------------------------------------------
module mux_seq #(
    parameter int NBYTES = 16,
    parameter int SEL_W  = 4
) (
    input  logic                  clk,
    input  logic                  nRst,
    input  logic [8*NBYTES-1:0]   in_data,
    input  logic [SEL_W-1:0]      in_start,
    input  logic [SEL_W-1:0]      in_cnt,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [8*NBYTES-1:0]   mux_in,
    output logic [SEL_W-1:0]      sel,
    input  logic [7:0]            mux_out,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  frame_done,
    output logic                  busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] SEL_ONE  = {{(SEL_W-1){1'b0}}, 1'b1};
    localparam logic [SEL_W-1:0] SEL_ZERO = {SEL_W{1'b0}};

    state_t                state_q;
    logic [8*NBYTES-1:0]   mux_in_q;
    logic [SEL_W-1:0]      sel_q;
    logic [SEL_W-1:0]      rem_q;
    logic                  frame_done_q;

    logic                  sending_s;
    logic                  beat_s;
    logic                  last_beat_s;
    logic                  accept_s;
    logic [SEL_W-1:0]      sel_d;

    // Handshake decode and next lane; in_ready opens only on the final beat
    // so a new word can never be taken mid-frame.
    always_comb begin
        sending_s   = 1'b0;
        beat_s      = 1'b0;
        last_beat_s = 1'b0;
        accept_s    = 1'b0;
        in_ready    = 1'b0;
        sel_d       = sel_q;
        if (state_q == ST_SEND) begin
            sending_s = 1'b1;
        end else begin
            sending_s = 1'b0;
        end
        beat_s      = sending_s & out_ready;
        last_beat_s = beat_s & (rem_q == SEL_ZERO);
        in_ready    = ~sending_s | last_beat_s;
        accept_s    = in_valid & in_ready;
`ifdef MUX_SEQ_DESCEND_EN
        sel_d       = sel_q - SEL_ONE;
`else
        sel_d       = sel_q + SEL_ONE;
`endif
    end

    // Frame sequencer: load on accept, step sel/rem per beat, and reload in
    // the same cycle as the last beat when the next word is already offered.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_q      <= ST_IDLE;
            mux_in_q     <= {(8*NBYTES){1'b0}};
            sel_q        <= SEL_ZERO;
            rem_q        <= SEL_ZERO;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= last_beat_s;
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        mux_in_q <= in_data;
                        sel_q    <= in_start;
                        rem_q    <= in_cnt;
                        state_q  <= ST_SEND;
                    end else begin
                        state_q  <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    if (!beat_s) begin
                        state_q <= ST_SEND;
                    end else if (!last_beat_s) begin
                        sel_q   <= sel_d;
                        rem_q   <= rem_q - SEL_ONE;
                    end else if (accept_s) begin
                        mux_in_q <= in_data;
                        sel_q    <= in_start;
                        rem_q    <= in_cnt;
                        state_q  <= ST_SEND;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mux_in     = mux_in_q;
    assign sel        = sel_q;
    assign out_data   = mux_out;
    assign out_valid  = sending_s;
    assign busy       = sending_s;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_mux_seq.sv
// Testbench for mux_seq: table-driven frames, hand-written back-to-back and
// mid-frame reset sequences, and randomized traffic against a queue-based
// reference of the byte stream each accepted word must produce.
module tb_mux_seq;

    logic         clk = 1'b0;
    logic         nRst;
    logic [127:0] in_data;
    logic [3:0]   in_start;
    logic [3:0]   in_cnt;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] mux_in;
    logic [3:0]   sel;
    logic [7:0]   mux_out;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready;
    logic         frame_done;
    logic         busy;

    always #5 clk = ~clk;

    // The external mux this controller feeds.
    assign mux_out = mux_in[8*sel +: 8];

    mux_seq dut (
        .clk        (clk),
        .nRst       (nRst),
        .in_data    (in_data),
        .in_start   (in_start),
        .in_cnt     (in_cnt),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mux_in     (mux_in),
        .sel        (sel),
        .mux_out    (mux_out),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_done (frame_done),
        .busy       (busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference: queue of the bytes (and their lanes) still owed to the consumer.
    typedef struct {
        logic [7:0] b;
        logic [3:0] lane;
    } beat_t;
    beat_t      exp_q[$];
    logic       exp_fd = 1'b0;
    logic [7:0] got_q[$];
    logic       accepted;
    int         fd_seen = 0;

    localparam logic [127:0] REF_W = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] W2    = 128'h0F0E0D0C0B0A09080706050403020100;

    typedef struct {
        logic [127:0] d;
        logic [3:0]   s;
        logic [3:0]   c;
        int           stall_at;
        logic [127:0] exp;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, req);
        end
    endtask

    function automatic void push_frame(input logic [127:0] d, input logic [3:0] s, input logic [3:0] c);
        for (int k = 0; k <= int'(c); k++) begin
            int    lane;
            beat_t e;
`ifdef MUX_SEQ_DESCEND_EN
            lane = (int'(s) - k + 16) % 16;
`else
            lane = (int'(s) + k) % 16;
`endif
            e.b    = d[8*lane +: 8];
            e.lane = lane[3:0];
            exp_q.push_back(e);
        end
    endfunction

    // One clock: called at a negedge with inputs already set, returns at the next negedge.
    task automatic step();
        logic exp_rdy, beat, fd_next;
        #1;
        exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
        chk("out_valid", {127'd0, out_valid}, {127'd0, exp_q.size() != 0});
        chk("busy", {127'd0, busy}, {127'd0, exp_q.size() != 0});
        chk("in_ready", {127'd0, in_ready}, {127'd0, exp_rdy});
        chk("frame_done", {127'd0, frame_done}, {127'd0, exp_fd});
        if (frame_done) fd_seen++;
        if (exp_q.size() != 0) begin
            chk("out_data", {120'd0, out_data}, {120'd0, exp_q[0].b});
            chk("sel", {124'd0, sel}, {124'd0, exp_q[0].lane});
        end
        beat     = (exp_q.size() != 0) && out_ready;
        accepted = in_valid && exp_rdy;
        fd_next  = beat && (exp_q.size() == 1);
        if (beat) begin
            got_q.push_back(out_data);
            void'(exp_q.pop_front());
        end
        if (accepted) push_frame(in_data, in_start, in_cnt);
        @(posedge clk);
        if (!nRst) begin
            exp_q.delete();
            exp_fd = 1'b0;
        end else begin
            exp_fd = fd_next;
        end
        @(negedge clk);
    endtask

    task automatic run_frame(input vec_t v, input string name);
        int           stalled = 0;
        logic [127:0] g = 128'd0;
        got_q.delete();
        in_data  = v.d;
        in_start = v.s;
        in_cnt   = v.c;
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 200 && got_q.size() < int'(v.c) + 1; cyc++) begin
            if (got_q.size() == v.stall_at && stalled < 3) begin
                out_ready = 1'b0;
                stalled++;
            end else begin
                out_ready = 1'b1;
            end
            step();
            if (accepted) in_valid = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk({name, "_count"}, 128'(got_q.size()), 128'(int'(v.c) + 1));
        for (int i = 0; i < got_q.size() && i < 16; i++) g[8*i +: 8] = got_q[i];
        chk({name, "_bytes"}, g, v.exp);
        step();
    endtask

    initial begin
        logic [127:0] g;
        vec_t         v;
        vecs[0] = '{REF_W, 4'd0,  4'd15, -1,
`ifdef MUX_SEQ_DESCEND_EN
                    128'hEEDDCCBBAA99887766554433221100FF};
`else
                    REF_W};
`endif
        vecs[1] = '{REF_W, 4'd14, 4'd3, -1,
`ifdef MUX_SEQ_DESCEND_EN
                    128'h44332211};
`else
                    128'hEEFF0011};
`endif
        vecs[2] = '{REF_W, 4'd5,  4'd2, 1,
`ifdef MUX_SEQ_DESCEND_EN
                    128'hCCBBAA};
`else
                    128'h8899AA};
`endif
        vecs[3] = '{REF_W, 4'd1,  4'd3, -1,
`ifdef MUX_SEQ_DESCEND_EN
                    128'h1100FFEE};
`else
                    128'hBBCCDDEE};
`endif
        vecs[4] = '{W2,    4'd0,  4'd1, -1,
`ifdef MUX_SEQ_DESCEND_EN
                    128'h0F00};
`else
                    128'h0100};
`endif

        nRst = 1'b0; in_data = 128'd0; in_start = 4'd0; in_cnt = 4'd0;
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mux_in", mux_in, 128'd0);
        chk("rst_sel", {124'd0, sel}, 128'd0);
        step();
        nRst = 1'b1;
        step();

        // Table-driven frames.
        for (int i = 0; i < 5; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back: second word offered while the first frame's last beat is up.
        got_q.delete();
        fd_seen  = 0;
        in_data  = REF_W; in_start = 4'd5; in_cnt = 4'd2; in_valid = 1'b1;
        for (int cyc = 0; cyc < 50 && got_q.size() < 5; cyc++) begin
            if (got_q.size() == 2) begin
                in_data = W2; in_start = 4'd0; in_cnt = 4'd1; in_valid = 1'b1;
            end
            step();
            if (accepted) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        step();
        g = 128'd0;
        for (int i = 0; i < got_q.size() && i < 16; i++) g[8*i +: 8] = got_q[i];
`ifdef MUX_SEQ_DESCEND_EN
        chk("b2b_bytes", g, 128'h0F00CCBBAA);
`else
        chk("b2b_bytes", g, 128'h01008899AA);
`endif
        chk("b2b_done_pulses", 128'(fd_seen), 128'd2);

        // Reset during the 4th beat of a full frame.
        got_q.delete();
        fd_seen  = 0;
        in_data  = REF_W; in_start = 4'd0; in_cnt = 4'd15; in_valid = 1'b1;
        for (int cyc = 0; cyc < 50 && got_q.size() < 3; cyc++) begin
            step();
            if (accepted) in_valid = 1'b0;
        end
        nRst = 1'b0;
        step();
        nRst = 1'b1;
        chk("midrst_mux_in", mux_in, 128'd0);
        chk("midrst_sel", {124'd0, sel}, 128'd0);
        step();
        step();
        chk("midrst_no_done", 128'(fd_seen), 128'd0);
        run_frame(vecs[1], "post_rst");

        // Randomized traffic; the producer holds its word until accepted.
        got_q.delete();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (!in_valid) begin
                in_valid = ($urandom_range(0, 2) == 0);
                in_data  = {$urandom, $urandom, $urandom, $urandom};
                in_start = 4'($urandom_range(0, 15));
                in_cnt   = 4'($urandom_range(0, 15));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
            if (accepted) in_valid = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && exp_q.size() != 0; cyc++) step();
        chk("drain_empty", 128'(exp_q.size()), 128'd0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
